// File: rtl/creg_rr_scheduler.sv
// Round-robin front end for a 5-port ordered concurrent register.
// Four requesters share ports 0..3; port 4 carries init/clear writes.
module creg_rr_scheduler #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   INIT_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           req_valid,
  input  logic [7:0]           req_op,
  input  logic [4*WIDTH-1:0]   req_data,
  output logic [3:0]           req_ready,
  output logic [3:0]           rsp_valid,
  output logic [4*WIDTH-1:0]   rsp_data,
  input  logic [3:0]           rsp_ready,
  input  logic                 halt_req,
  input  logic                 resume_req,
  input  logic                 clear_req,
  output logic                 halted,
  output logic [4:0]           creg_en,
  output logic [5*WIDTH-1:0]   creg_d,
  input  logic [5*WIDTH-1:0]   creg_q
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         rsp_valid_q, rsp_valid_d;
  logic [4*WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic               run;
  logic [3:0]         grant;
  logic [1:0]         port [4];
  logic [WIDTH-1:0]   q_at [4];
  logic [WIDTH-1:0]   d_at [4];
  logic [1:0]         op_at [4];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN:  if (halt_req) state_d = S_HALT;
      S_HALT: if (resume_req && !halt_req) state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign run       = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign req_ready = {4{run}} & ~(rsp_valid_q & ~rsp_ready);
  assign grant     = req_valid & req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Requester i lands on port (i - ptr) mod 4.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      port[i]  = 2'(i) - ptr_q;
      q_at[i]  = creg_q[WIDTH*int'(port[i]) +: WIDTH];
      d_at[i]  = req_data[WIDTH*i +: WIDTH];
      op_at[i] = req_op[2*i +: 2];
    end
  end

  always_comb begin
    creg_en     = '0;
    creg_d      = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]             = 1'b1;
        rsp_data_d[WIDTH*i +: WIDTH] = q_at[i];
        unique case (op_at[i])
          2'b01: begin
            creg_en[{1'b0, port[i]}] = 1'b1;
            creg_d[WIDTH*int'(port[i]) +: WIDTH] = d_at[i];
          end
          2'b10: begin
            creg_en[{1'b0, port[i]}] = 1'b1;
            creg_d[WIDTH*int'(port[i]) +: WIDTH] = q_at[i] + d_at[i];
          end
          2'b11: begin
            creg_en[{1'b0, port[i]}] = 1'b1;
            creg_d[WIDTH*int'(port[i]) +: WIDTH] = q_at[i] & ~d_at[i];
          end
          default: ;
        endcase
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    // Port 4 is last in order, so a clear wins over this cycle's writes.
    if (state_q == S_INIT || clear_req) begin
      creg_en[4]              = 1'b1;
      creg_d[4*WIDTH +: WIDTH] = INIT_VAL;
    end
    if (|grant) ptr_d = ptr_q + 2'd1;
  end

endmodule

// File: tb/tb_creg_rr_scheduler.sv
// Directed + random bench for creg_rr_scheduler; the shared register
// and the scheduling rules are modelled as a serial list of ops.
module tb_creg_rr_scheduler;

  localparam int W = 16;
  localparam logic [W-1:0] IV = 16'd5;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [3:0]    rv, rr, req_ready, rsp_valid;
  logic [7:0]    op;
  logic [4*W-1:0] dat, rsp_data;
  logic          hr, rs, cr, halted;
  logic [4:0]    creg_en;
  logic [5*W-1:0] creg_d, creg_q;

  int n_assert = 0;
  int n_fail   = 0;

  int         mst;
  int         mptr;
  logic [W-1:0] mreg;
  logic [3:0] mrv;
  logic [W-1:0] mrd [4];

  creg_rr_scheduler #(.WIDTH(W), .INIT_VAL(IV)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(rv), .req_op(op), .req_data(dat),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rr),
    .halt_req(hr), .resume_req(rs), .clear_req(cr),
    .halted(halted),
    .creg_en(creg_en), .creg_d(creg_d), .creg_q(creg_q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] v, input logic [7:0] o,
                     input logic [4*W-1:0] d);
    rv = v; op = o; dat = d;
  endtask

  task automatic chk_rsp();
    chk("rsp_valid", 64'(rsp_valid), 64'(mrv));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rsp_data%0d", i), 64'(rsp_data[W*i +: W]),
          64'(mrd[i]));
    chk("halted", 64'(halted), 64'(mst == 2));
  endtask

  // One clock: check combinational outputs, clock, check registered ones.
  task automatic cyc();
    logic [W-1:0] v, dv, nrd [4];
    logic [W-1:0] pq [5];
    logic [W-1:0] ed [5];
    logic [3:0]   rdy, g, nrv;
    logic [4:0]   een;
    if (!RST_N) begin
      creg_q = {5{mreg}};
      @(posedge CLK);
      mst = 0; mptr = 0; mrv = '0;
      for (int i = 0; i < 4; i++) mrd[i] = '0;
      @(negedge CLK);
      chk_rsp();
      return;
    end
    for (int i = 0; i < 4; i++)
      rdy[i] = (mst == 1) && !(mrv[i] && !rr[i]);
    g = rv & rdy;
    v = mreg; een = '0; nrv = mrv;
    for (int k = 0; k < 5; k++) ed[k] = '0;
    for (int i = 0; i < 4; i++) nrd[i] = mrd[i];
    for (int k = 0; k < 4; k++) begin
      automatic int i = (mptr + k) % 4;
      pq[k] = v;
      dv = dat[W*i +: W];
      if (g[i]) begin
        nrv[i] = 1'b1;
        nrd[i] = v;
        case (op[2*i +: 2])
          2'b01: v = dv;
          2'b10: v = v + dv;
          2'b11: v = v & ~dv;
          default: ;
        endcase
        if (op[2*i +: 2] != 2'b00) begin
          een[k] = 1'b1;
          ed[k]  = v;
        end
      end else if (mrv[i] && rr[i]) begin
        nrv[i] = 1'b0;
      end
    end
    pq[4] = v;
    if (mst == 0 || cr) begin
      een[4] = 1'b1; ed[4] = IV; v = IV;
    end
    creg_q = {pq[4], pq[3], pq[2], pq[1], pq[0]};
    #1;
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("creg_en", 64'(creg_en), 64'(een));
    for (int k = 0; k < 5; k++)
      chk($sformatf("creg_d%0d", k), 64'(creg_d[W*k +: W]), 64'(ed[k]));
    @(posedge CLK);
    mreg = v; mrv = nrv;
    for (int i = 0; i < 4; i++) mrd[i] = nrd[i];
    if (mst == 1 && g != 0) mptr = (mptr + 1) % 4;
    case (mst)
      0: mst = 1;
      1: if (hr) mst = 2;
      default: if (rs && !hr) mst = 1;
    endcase
    @(negedge CLK);
    chk_rsp();
  endtask

  initial begin
    mreg = '0; mst = 0; mptr = 0; mrv = '0;
    for (int i = 0; i < 4; i++) mrd[i] = '0;
    RST_N = 1'b0; rr = 4'hF; hr = 0; rs = 0; cr = 0;
    req(4'h0, 8'h00, '0);
    creg_q = '0;
    cyc(); cyc();
    RST_N = 1'b1;
    // T1: INIT cycle then RUN
    cyc();
    cyc();
    // bring reg to 10 with ptr back at 0
    req(4'h1, 8'h01, 64'd10); cyc();
    req(4'h1, 8'h00, '0); cyc(); cyc(); cyc();
    // T2: four adds serialised from ptr 0
    req(4'hF, 8'hAA, {4{16'd1}}); cyc();
    chk("T2_rsp", 64'(rsp_data), {16'd13, 16'd12, 16'd11, 16'd10});
    // T3: clear reg to 0, walk ptr to 1
    req(4'h1, 8'h03, 64'hFFFF); cyc();
    req(4'h1, 8'h00, '0); cyc(); cyc(); cyc();
    req(4'h3, 8'h01, {16'd0, 16'd0, 16'd0, 16'd7}); cyc();
    chk("T3_rsp", 64'(rsp_data[2*W-1:0]), 64'd0);
    // T4: stalled response blocks only its requester
    rr = 4'b1011;
    req(4'h4, 8'h00, '0); cyc();
    req(4'h0, 8'h00, '0); cyc();
    rr = 4'hF; cyc();
    // T5: halt, clear while halted, halt+resume, resume
    hr = 1; req(4'h1, 8'h01, 64'd3); cyc();
    hr = 0; req(4'h0, 8'h00, '0); cyc();
    cr = 1; cyc(); cr = 0;
    hr = 1; rs = 1; cyc(); hr = 0;
    cyc(); rs = 0;
    cyc();
    // T6: bit-clear with clear_req, then reset with a pending response
    req(4'h1, 8'h01, 64'd9); cyc();
    cr = 1; req(4'h1, 8'h03, 64'd1); cyc(); cr = 0;
    chk("T6_rsp0", 64'(rsp_data[W-1:0]), 64'd9);
    rr = 4'h0; req(4'h1, 8'h00, '0); cyc();
    RST_N = 1'b0; cyc(); RST_N = 1'b1;
    rr = 4'hF; req(4'h0, 8'h00, '0); cyc(); cyc();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      req(4'($urandom), 8'($urandom), {$urandom, $urandom});
      rr = 4'($urandom);
      hr = ($urandom % 10) == 0;
      rs = ($urandom % 4) == 0;
      cr = ($urandom % 12) == 0;
      RST_N = ($urandom % 100) != 0;
      cyc();
    end
    RST_N = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
